// File: rtl/FetchUnitTypes.sv
// Fetch-unit shared types: PHT index/counter paths, update-queue entry,
// queue sizing, starvation limit and the 2-bit saturating counter step.
package FetchUnitTypes;

  localparam int PHT_ENTRY_NUM_BIT_WIDTH = 10;

  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0] PHT_IndexPath;
  typedef logic [1:0] PHT_EntryPath;

  typedef struct packed {
    PHT_IndexPath index;
    PHT_EntryPath value;
  } PhtUpdateEntry;

  localparam int PHT_UPDATE_QUEUE_SIZE = 32;
  localparam int PHT_UPDATE_QUEUE_PTR_W =
    $clog2(PHT_UPDATE_QUEUE_SIZE);

  typedef logic [PHT_UPDATE_QUEUE_PTR_W-1:0]
    PhtUpdateQueuePointerPath;

  localparam int PHT_MAX_WAIT = 8;

  function automatic PHT_EntryPath PhtSatUpdate(
    input PHT_EntryPath prev,
    input logic         taken
  );
    PHT_EntryPath r;
    r = prev;
    unique case (1'b1)
      taken && (prev != 2'd3):  r = prev + 2'd1;
      !taken && (prev != 2'd0): r = prev - 2'd1;
      default:                  r = prev;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pht_update_queue.sv
// Multi-enqueue / single-dequeue circular FIFO of PHT update entries.
// Ports: enqValid_i/enqData_i lanes, deq_i pop, head_o, count_o occupancy.
module pht_update_queue
  import FetchUnitTypes::*;
#(
  parameter int SIZE  = PHT_UPDATE_QUEUE_SIZE,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       enqValid_i,
  input  PhtUpdateEntry          enqData_i [LANES],
  input  logic                   deq_i,
  output PhtUpdateEntry          head_o,
  output logic [$clog2(SIZE):0]  count_o
);

  localparam int PW = $clog2(SIZE);
  localparam int CW = PW + 1;

  PhtUpdateEntry mem_q [SIZE];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] slot [LANES];
  logic [CW-1:0] nEnq;

  // Lanes are packed in lane order: each valid lane lands at
  // tail plus the number of valid lanes below it.
  always_comb begin
    nEnq = '0;
    for (int l = 0; l < LANES; l++) begin
      slot[l] = tail_q + PW'(nEnq);
      if (enqValid_i[l]) nEnq = nEnq + CW'(1);
    end
    head_d  = deq_i ? head_q + PW'(1) : head_q;
    tail_d  = tail_q + PW'(nEnq);
    count_d = count_q + nEnq - {{(CW-1){1'b0}}, deq_i};
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (enqValid_i[l]) mem_q[slot[l]] <= enqData_i[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/pht_update_scheduler.sv
// PHT update scheduler: queues committed branch outcomes and arbitrates
// the single-port PHT between fetch reads and update writes.
// Ports: upd* commit lanes, full/count, rdReq/rdGrant, phtWE/WA/WV.
module pht_update_scheduler
  import FetchUnitTypes::*;
#(
  parameter int QUEUE_SIZE   = PHT_UPDATE_QUEUE_SIZE,
  parameter int UPDATE_WIDTH = 2,
  parameter int INDEX_WIDTH  = PHT_ENTRY_NUM_BIT_WIDTH,
  parameter int MAX_WAIT     = PHT_MAX_WAIT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [UPDATE_WIDTH-1:0]                 updValid,
  input  logic [UPDATE_WIDTH-1:0][INDEX_WIDTH-1:0] updIndex,
  input  logic [UPDATE_WIDTH-1:0]                 updTaken,
  input  logic [UPDATE_WIDTH-1:0][1:0]            updPrev,
  output logic                                    full,
  output logic [$clog2(QUEUE_SIZE):0]             count,
  input  logic                                    rdReq,
  output logic                                    rdGrant,
  output logic                                    phtWE,
  output logic [INDEX_WIDTH-1:0]                  phtWA,
  output logic [1:0]                              phtWV
);

  localparam int CW = $clog2(QUEUE_SIZE) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_THR =
    CW'(QUEUE_SIZE - UPDATE_WIDTH);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  PhtUpdateEntry           enqData [UPDATE_WIDTH];
  PhtUpdateEntry           head;
  logic [UPDATE_WIDTH-1:0] enqValid;
  logic [WW-1:0]           waitCnt_q, waitCnt_d;
  logic                    empty;
  logic                    forceWr;

  // Only the post-update counter value is kept; prev/taken are
  // consumed here at enqueue.
  always_comb begin
    for (int l = 0; l < UPDATE_WIDTH; l++) begin
      enqData[l].index = PHT_IndexPath'(updIndex[l]);
      enqData[l].value = PhtSatUpdate(updPrev[l], updTaken[l]);
    end
  end

  assign full     = count > FULL_THR;
  assign enqValid = full ? '0 : updValid;

  pht_update_queue #(
    .SIZE  (QUEUE_SIZE),
    .LANES (UPDATE_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .enqValid_i (enqValid),
    .enqData_i  (enqData),
    .deq_i      (phtWE),
    .head_o     (head),
    .count_o    (count)
  );

  // Fetch owns the port unless the head has waited MAX_WAIT cycles.
  assign empty   = count == '0;
  assign forceWr = !empty && (waitCnt_q == WAIT_SAT);
  assign phtWE   = !empty && (!rdReq || forceWr);
  assign rdGrant = rdReq && !forceWr;
  assign phtWA   = INDEX_WIDTH'(head.index);
  assign phtWV   = head.value;

  always_comb begin
    waitCnt_d = waitCnt_q;
    unique case (1'b1)
      phtWE || empty:
        waitCnt_d = '0;
      !empty && rdReq && !forceWr:
        waitCnt_d = waitCnt_q + WW'(1);
      default:
        waitCnt_d = waitCnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) waitCnt_q <= '0;
    else     waitCnt_q <= waitCnt_d;
  end

  // Commit must honour full; anything offered while full is lost.
  a_no_enq_when_full: assert property (
    @(posedge clk) disable iff (rst) !(full && (|updValid))
  );

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler: counter math, lane packing,
// starvation forcing, fill/full/wrap and mid-run reset.
module tb_pht_update_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      updValid;
  logic [1:0][9:0] updIndex;
  logic [1:0]      updTaken;
  logic [1:0][1:0] updPrev;
  logic            full;
  logic [5:0]      count;
  logic            rdReq;
  logic            rdGrant;
  logic            phtWE;
  logic [9:0]      phtWA;
  logic [1:0]      phtWV;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pht_update_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .updValid (updValid),
    .updIndex (updIndex),
    .updTaken (updTaken),
    .updPrev  (updPrev),
    .full     (full),
    .count    (count),
    .rdReq    (rdReq),
    .rdGrant  (rdGrant),
    .phtWE    (phtWE),
    .phtWA    (phtWA),
    .phtWV    (phtWV)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    updValid = '0;
  endtask

  task automatic put(input int l, input int idx, input bit tk,
                     input int pv);
    updValid[l] = 1'b1;
    updIndex[l] = 10'(idx);
    updTaken[l] = tk;
    updPrev[l]  = 2'(pv);
  endtask

  function automatic logic [1:0] sat(input int pv, input bit tk);
    if (tk) return (pv == 3) ? 2'd3 : 2'(pv + 1);
    else    return (pv == 0) ? 2'd0 : 2'(pv - 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rdReq = 1'b0;
    updValid = '0;
    updIndex = '0;
    updTaken = '0;
    updPrev = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_we", phtWE, 0);
    chk("rst_grant0", rdGrant, 0);
    rdReq = 1'b1;
    #1;
    chk("rst_grant1", rdGrant, 1);
    chk("rst_we_rd", phtWE, 0);
    rdReq = 1'b0;
    tick();

    // basic: idx5 taken prev1 -> 2, one cycle latency
    put(0, 5, 1, 1);
    #1;
    chk("b_we_empty", phtWE, 0);
    tick();
    idle();
    #1;
    chk("b_count", count, 1);
    chk("b_we", phtWE, 1);
    chk("b_wa", phtWA, 5);
    chk("b_wv", phtWV, 2);
    tick();
    #1;
    chk("b_count0", count, 0);
    chk("b_we0", phtWE, 0);

    // saturation both ends, back-to-back enqueue/dequeue
    put(0, 3, 1, 3);
    #1;
    tick();
    idle();
    put(0, 4, 0, 0);
    #1;
    chk("s_we", phtWE, 1);
    chk("s_wa3", phtWA, 3);
    chk("s_wv3", phtWV, 3);
    tick();
    idle();
    #1;
    chk("s_count", count, 1);
    chk("s_wa4", phtWA, 4);
    chk("s_wv0", phtWV, 0);
    tick();
    #1;
    chk("s_count0", count, 0);

    // two lanes, then lane1 only
    put(0, 7, 0, 2);
    put(1, 9, 1, 2);
    #1;
    tick();
    idle();
    #1;
    chk("d_count2", count, 2);
    chk("d_wa7", phtWA, 7);
    chk("d_wv1", phtWV, 1);
    tick();
    #1;
    chk("d_count1", count, 1);
    chk("d_we", phtWE, 1);
    chk("d_wa9", phtWA, 9);
    chk("d_wv3", phtWV, 3);
    tick();
    #1;
    chk("d_count0", count, 0);
    put(1, 11, 0, 1);
    #1;
    tick();
    idle();
    #1;
    chk("l1_count", count, 1);
    chk("l1_wa", phtWA, 11);
    chk("l1_wv", phtWV, 0);
    tick();
    #1;
    chk("l1_count0", count, 0);

    // starvation: 8 granted reads, then a forced write
    rdReq = 1'b1;
    put(0, 13, 1, 0);
    #1;
    chk("st_grant0", rdGrant, 1);
    tick();
    idle();
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("st_grant", rdGrant, 1);
      chk("st_we0", phtWE, 0);
      tick();
    end
    #1;
    chk("st_force_we", phtWE, 1);
    chk("st_force_gnt", rdGrant, 0);
    chk("st_force_wa", phtWA, 13);
    chk("st_force_wv", phtWV, 1);
    tick();
    #1;
    chk("st_after_gnt", rdGrant, 1);
    chk("st_after_cnt", count, 0);
    tick();

    // fill at 2/cycle under continuous rdReq; head/tail start at 7
    for (int k = 0; k < 16; k++) begin
      put(0, 100 + 2 * k, 0, k & 3);
      put(1, 101 + 2 * k, 1, k & 3);
      #1;
      chk("f_full0", full, 0);
      chk("f_grant", rdGrant, (k != 9));
      if (k == 9) begin
        chk("f_force_we", phtWE, 1);
        chk("f_force_wa", phtWA, 100);
        chk("f_force_wv", phtWV, 0);
      end
      tick();
    end
    idle();
    #1;
    chk("f_full1", full, 1);
    chk("f_count31", count, 31);
    chk("f_grant_full", rdGrant, 1);
    tick();
    rdReq = 1'b0;
    for (int n = 1; n < 32; n++) begin
      #1;
      chk("dr_count", count, 32 - n);
      chk("dr_we", phtWE, 1);
      chk("dr_wa", phtWA, 100 + n);
      chk("dr_wv", phtWV, sat((n >> 1) & 3, n[0]));
      tick();
    end
    #1;
    chk("dr_count0", count, 0);
    chk("dr_we0", phtWE, 0);
    chk("dr_full0", full, 0);

    // reset while holding 10 entries
    rdReq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      put(0, 200 + 2 * k, 1, 1);
      put(1, 201 + 2 * k, 0, 2);
      #1;
      tick();
    end
    idle();
    #1;
    chk("r_count10", count, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdReq = 1'b0;
    #1;
    chk("r_count0", count, 0);
    chk("r_we0", phtWE, 0);
    chk("r_full0", full, 0);
    put(0, 21, 1, 2);
    #1;
    tick();
    idle();
    #1;
    chk("r_we", phtWE, 1);
    chk("r_wa", phtWA, 21);
    chk("r_wv", phtWV, 3);
    chk("r_count1", count, 1);
    tick();
    #1;
    chk("r_end_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Buffers committed conditional-branch results in a circular queue.
- Computes each PHT counter's new 2-bit saturating value at enqueue.
- Arbitrates the single-port PHT block RAM between fetch-stage prediction reads and queued update writes.
- Sits between the commit-stage branch-result path and the PHT array. A starvation timer guarantees update forward progress.

Parameters:
- QUEUE_SIZE, 32: queue entries; power of two.
- UPDATE_WIDTH, 2: branch results accepted per cycle.
- INDEX_WIDTH, PHT_ENTRY_NUM_BIT_WIDTH: PHT index width.
- MAX_WAIT, 8: cycles the queue head may be blocked before a write is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- updValid  in  UPDATE_WIDTH  per-lane update valid
- updIndex  in  UPDATE_WIDTH x INDEX_WIDTH  PHT index of the branch
- updTaken  in  UPDATE_WIDTH  execution direction
- updPrev  in  UPDATE_WIDTH x 2  PHT counter value read at prediction
- full  out  1  queue cannot accept UPDATE_WIDTH entries next cycle; commit must stall
- count  out  $clog2(QUEUE_SIZE)+1  current occupancy
- rdReq  in  1  fetch requests a PHT read this cycle
- rdGrant  out  1  fetch read permitted this cycle
- phtWE  out  1  PHT write enable
- phtWA  out  INDEX_WIDTH  PHT write index
- phtWV  out  2  PHT write value

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high.
- Reset values: head=0, tail=0, count=0, waitCnt=0.
  - Outputs after reset: full=0, phtWE=0, rdGrant=rdReq.
- Counter arithmetic at enqueue:
  - Taken: new = (prev==3) ? 3 : prev+1.
  - Not taken: new = (prev==0) ? 0 : prev-1.
  - Only {index, new} is stored.
- Enqueue:
  - Valid lanes are compacted in lane order (lane 0 first) into tail, tail+1, ...
  - tail advances by popcount(updValid), modulo QUEUE_SIZE (natural wrap).
  - An entry is visible at head no earlier than the cycle after enqueue, so minimum update-to-write latency is 1 cycle.
- full = (count > QUEUE_SIZE - UPDATE_WIDTH), combinational from registered count.
  - Any updValid while full=1 is a protocol violation: simulation assertion; data dropped.
- Arbitration, combinational each cycle. Let empty = (count==0) and force = !empty && waitCnt==MAX_WAIT.
  - phtWE = !empty && (!rdReq || force).
  - rdGrant = rdReq && !force.
  - phtWA and phtWV come from the head entry; don't-care when phtWE=0.
- Dequeue:
  - When phtWE=1, head advances by 1 with wrap.
  - count_next = count + enq - deq. Simultaneous enqueue and dequeue is legal at any occupancy.
- Starvation counter waitCnt:
  - Reset to 0 on any write or when empty.
  - Otherwise, when rdReq blocks the head, increments, saturating at MAX_WAIT.
  - Therefore at most one forced write per MAX_WAIT+1 cycles under continuous rdReq.
- Fetch must treat rdGrant=0 as a one-cycle fetch stall and re-issue the read.
- Duplicate indices in the queue are written in order; the last write wins. No coalescing.
- Reset mid-operation clears all pending updates. Loss of predictor training is acceptable.

Decomposition:
- Shared package (FetchUnitTypes), new contents:
  - PhtUpdateEntry struct {PHT_IndexPath index; PHT_EntryPath value}.
  - PHT_UPDATE_QUEUE_SIZE constant and PhtUpdateQueuePointerPath typedef.
  - PHT_MAX_WAIT constant.
  - Function PhtSatUpdate(prev, taken) returning PHT_EntryPath.
- One sub-module, pht_update_queue: the multi-enqueue, single-dequeue circular FIFO (pointers, count, storage).
- The top module holds the counter-update logic, waitCnt and arbitration.

Test Plan:
- Reset, then lane0 {idx=5, taken=1, prev=1}, rdReq=0 -> next cycle phtWE=1, phtWA=5, phtWV=2; count returns to 0.
- Saturation: prev=3, taken=1 -> phtWV=3. Then prev=0, taken=0 -> phtWV=0.
- Both lanes valid {idx=7, prev=2, taken=0} and {idx=9, prev=2, taken=1}, rdReq=0 -> two consecutive writes: (7,1) then (9,3). Lane1-only update enqueues as a single entry.
- rdReq held 1 with one entry queued -> rdGrant=1 for 8 cycles. Cycle 9: phtWE=1, rdGrant=0. Then rdGrant=1 again and waitCnt=0.
- Fill with rdReq=1 continuously and 2 updates/cycle -> full asserts when count reaches 31. Drain then wraps head and tail past index 31 to 0 with data intact.
- rst asserted while count=10 -> next cycle count=0, phtWE=0, full=0. A new update after reset writes correctly.
